// File: rtl/bresenham_line_drawer.sv
// Bresenham line rasteriser: takes two endpoints and streams each pixel of the line
// over a valid/ready handshake. Emits a one-cycle done pulse after the last pixel.
module bresenham_line_drawer #(
    parameter int unsigned COORD_W = 10
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [COORD_W-1:0] p_x,
    input  logic [COORD_W-1:0] p_y,
    input  logic [COORD_W-1:0] q_x,
    input  logic [COORD_W-1:0] q_y,
    input  logic               pixel_ready,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_valid,
    output logic               busy,
    output logic               done
);

    localparam int unsigned EW = COORD_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               state, state_nxt;
    logic [COORD_W-1:0]       x0, y0, x1, y1;
    logic [COORD_W-1:0]       x0_nxt, y0_nxt, x1_nxt, y1_nxt;
    logic signed [EW-1:0]     dx, dy, err;
    logic signed [EW-1:0]     dx_nxt, dy_nxt, err_nxt;
    logic                     sx, sy, sx_nxt, sy_nxt;
    logic [COORD_W-1:0]       pixel_x_nxt, pixel_y_nxt;
    logic                     pixel_valid_nxt, busy_nxt, done_nxt;

    logic signed [EW-1:0]     diff_x, diff_y, abs_x, abs_y, e2;
    logic                     step_x, step_y, at_end, xfer;

    // Endpoint deltas, zero-extended so the subtraction never overflows.
    assign diff_x = $signed(EW'(x1)) - $signed(EW'(x0));
    assign diff_y = $signed(EW'(y1)) - $signed(EW'(y0));
    assign abs_x  = diff_x[EW-1] ? -diff_x : diff_x;
    assign abs_y  = diff_y[EW-1] ? -diff_y : diff_y;

    assign e2     = $signed({err[EW-2:0], 1'b0});
    assign step_x = (e2 >= dy);
    assign step_y = (e2 <= dx);
    assign at_end = (pixel_x == x1) && (pixel_y == y1);
    assign xfer   = pixel_valid && pixel_ready;

    // Next-state and next-register logic.
    always_comb begin
        state_nxt       = state;
        x0_nxt          = x0;
        y0_nxt          = y0;
        x1_nxt          = x1;
        y1_nxt          = y1;
        dx_nxt          = dx;
        dy_nxt          = dy;
        err_nxt         = err;
        sx_nxt          = sx;
        sy_nxt          = sy;
        pixel_x_nxt     = pixel_x;
        pixel_y_nxt     = pixel_y;
        pixel_valid_nxt = pixel_valid;
        busy_nxt        = busy;
        done_nxt        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    x0_nxt    = p_x;
                    y0_nxt    = p_y;
                    x1_nxt    = q_x;
                    y1_nxt    = q_y;
                    busy_nxt  = 1'b1;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_nxt          = abs_x;
                dy_nxt          = -abs_y;
                sx_nxt          = (x0 < x1);
                sy_nxt          = (y0 < y1);
                err_nxt         = abs_x - abs_y;
                pixel_x_nxt     = x0;
                pixel_y_nxt     = y0;
                pixel_valid_nxt = 1'b1;
                state_nxt       = S_DRAW;
            end
            S_DRAW: begin
                if (xfer) begin
                    if (at_end) begin
                        pixel_valid_nxt = 1'b0;
                        done_nxt        = 1'b1;
                        state_nxt       = S_DONE;
                    end else begin
                        // Both axis decisions use the pre-update error term.
                        err_nxt = err + (step_x ? dy : EW'(0)) + (step_y ? dx : EW'(0));
                        if (step_x) pixel_x_nxt = sx ? pixel_x + COORD_W'(1) : pixel_x - COORD_W'(1);
                        if (step_y) pixel_y_nxt = sy ? pixel_y + COORD_W'(1) : pixel_y - COORD_W'(1);
                    end
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            x0          <= '0;
            y0          <= '0;
            x1          <= '0;
            y1          <= '0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            sx          <= 1'b0;
            sy          <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            x0          <= x0_nxt;
            y0          <= y0_nxt;
            x1          <= x1_nxt;
            y1          <= y1_nxt;
            dx          <= dx_nxt;
            dy          <= dy_nxt;
            err         <= err_nxt;
            sx          <= sx_nxt;
            sy          <= sy_nxt;
            pixel_x     <= pixel_x_nxt;
            pixel_y     <= pixel_y_nxt;
            pixel_valid <= pixel_valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Directed bench for bresenham_line_drawer: hand-computed pixel sequences, stalls,
// mid-line reset and ignored start pulses.
module tb_bresenham_line_drawer;

    localparam int unsigned COORD_W = 10;
    localparam int          MAX_CYC = 2000;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               start;
    logic [COORD_W-1:0] p_x, p_y, q_x, q_y;
    logic               pixel_ready;
    logic [COORD_W-1:0] pixel_x, pixel_y;
    logic               pixel_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int exp_x[$];
    int exp_y[$];
    int got_x[$];
    int got_y[$];

    bresenham_line_drawer #(.COORD_W(COORD_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .p_x         (p_x),
        .p_y         (p_y),
        .q_x         (q_x),
        .q_y         (q_y),
        .pixel_ready (pixel_ready),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic add_px(input int x, input int y);
        exp_x.push_back(x);
        exp_y.push_back(y);
    endtask

    // Draw one line; optionally stall on pixel stall_idx and poke start at pixel poke_idx.
    task automatic run_line(input int pxv, input int pyv, input int qxv, input int qyv,
                            input int stall_idx, input int stall_len, input int poke_idx);
        int stalls = 0;
        int cycles = 0;
        bit poked  = 0;
        int held_x = 0;
        int held_y = 0;
        p_x = COORD_W'(pxv); p_y = COORD_W'(pyv);
        q_x = COORD_W'(qxv); q_y = COORD_W'(qyv);
        start = 1'b1;
        pixel_ready = 1'b1;
        wait_clk;
        start = 1'b0;
        check("setup_busy", 32'(busy), 1);
        check("setup_valid", 32'(pixel_valid), 0);
        wait_clk;
        check("first_valid", 32'(pixel_valid), 1);
        got_x.delete();
        got_y.delete();
        while (done !== 1'b1 && cycles < MAX_CYC) begin
            start = 1'b0;
            if (got_x.size() == poke_idx && !poked) begin
                poked = 1;
                start = 1'b1;
                p_x = COORD_W'(7); p_y = COORD_W'(7);
                q_x = COORD_W'(100); q_y = COORD_W'(50);
            end
            if (pixel_valid) begin
                if (got_x.size() == stall_idx && stalls < stall_len) begin
                    pixel_ready = 1'b0;
                    if (stalls == 0) begin
                        held_x = int'(pixel_x);
                        held_y = int'(pixel_y);
                    end else begin
                        check("stall_hold_x", 32'(pixel_x), 32'(held_x));
                        check("stall_hold_y", 32'(pixel_y), 32'(held_y));
                    end
                    stalls++;
                end else begin
                    pixel_ready = 1'b1;
                    got_x.push_back(int'(pixel_x));
                    got_y.push_back(int'(pixel_y));
                end
            end else begin
                check("valid_in_draw", 32'(pixel_valid), 1);
            end
            wait_clk;
            cycles++;
        end
        start = 1'b0;
        if (cycles >= MAX_CYC) check("timeout_done", 0, 1);
        check("done_pulse", 32'(done), 1);
        check("done_valid", 32'(pixel_valid), 0);
        check("done_busy", 32'(busy), 1);
        wait_clk;
        check("done_clear", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("pix_count", 32'(got_x.size()), 32'(exp_x.size()));
        for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
            check($sformatf("pix%0d_x", i), 32'(got_x[i]), 32'(exp_x[i]));
            check($sformatf("pix%0d_y", i), 32'(got_y[i]), 32'(exp_y[i]));
        end
        exp_x.delete();
        exp_y.delete();
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b1;
        pixel_ready = 1'b1;
        p_x = '0; p_y = '0; q_x = COORD_W'(3); q_y = '0;
        wait_clk;
        wait_clk;
        start = 1'b0;
        check("rst_valid", 32'(pixel_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_px", 32'(pixel_x), 0);
        check("rst_py", 32'(pixel_y), 0);
        n_rst = 1'b1;
        wait_clk;
        check("start_in_rst_ignored", 32'(busy), 0);

        // Degenerate single point
        add_px(5, 5);
        run_line(5, 5, 5, 5, -1, 0, -1);

        // Horizontal
        add_px(0, 0); add_px(1, 0); add_px(2, 0); add_px(3, 0);
        run_line(0, 0, 3, 0, -1, 0, -1);

        // Steep, negative direction
        add_px(2, 5); add_px(2, 4); add_px(1, 3); add_px(1, 2); add_px(0, 1); add_px(0, 0);
        run_line(2, 5, 0, 0, -1, 0, -1);

        // Diagonal with backpressure on the second pixel
        add_px(0, 0); add_px(1, 1); add_px(2, 2); add_px(3, 3);
        run_line(0, 0, 3, 3, 1, 3, -1);

        // Start pulsed mid-line must be ignored
        add_px(10, 0); add_px(9, 1); add_px(8, 1); add_px(7, 2); add_px(6, 2);
        run_line(10, 0, 6, 2, -1, 0, 2);

        // Top-edge endpoints
        add_px(1023, 1023); add_px(1022, 1022); add_px(1021, 1022);
        run_line(1023, 1023, 1021, 1022, -1, 0, -1);

        // Full-range anti-diagonal
        for (int i = 0; i < 1024; i++) add_px(i, 1023 - i);
        run_line(0, 1023, 1023, 0, -1, 0, -1);

        // Reset mid-line aborts with no done pulse
        p_x = '0; p_y = '0; q_x = COORD_W'(9); q_y = '0;
        start = 1'b1;
        pixel_ready = 1'b1;
        wait_clk;
        start = 1'b0;
        wait_clk;
        check("rl_pix0", 32'(pixel_x), 0);
        wait_clk;
        wait_clk;
        check("rl_pix2", 32'(pixel_x), 2);
        wait_clk;
        n_rst = 1'b0;
        wait_clk;
        n_rst = 1'b1;
        check("rl_valid", 32'(pixel_valid), 0);
        check("rl_busy", 32'(busy), 0);
        check("rl_done", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
            wait_clk;
            check("rl_quiet_valid", 32'(pixel_valid), 0);
            check("rl_quiet_done", 32'(done), 0);
        end

        add_px(1, 1); add_px(2, 2); add_px(3, 2);
        run_line(1, 1, 3, 2, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
